fib_seq_ctrl: RTL and testbench
===============================

# fib_seq_ctrl

Sequencing controller for the 16-bit Fibonacci term generator. On a start request it clears the generator and steps it exactly `count` times. It captures each term and delivers it to a downstream consumer over a valid/ready handshake, with a programmable idle gap between generator steps. It sits between the system control logic and one generator instance; it is the only block that drives the generator's enable and clear.

## Interface
- `CNT_W`, 8 — width of the term counter and of the term index.
- `GAP`, 0 — idle cycles inserted between the acceptance of one term and the next generator step (0..255).
- `clk` in 1 — clock; everything is clocked on the rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `start` in 1 — job request; sampled only in IDLE.
- `count` in CNT_W — number of terms for the job; sampled together with `start`.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse when a job ends.
- `err` out 1 — sticky protocol error; cleared by the next accepted `start`.
- `ovf` out 1 — sticky overflow flag (see Configuration); cleared by the next accepted `start`.
- `gen_rst` out 1 — generator clear; one-cycle pulse.
- `gen_en` out 1 — generator step; one-cycle pulse.
- `gen_valid` in 1 — generator output-valid flag.
- `gen_out` in 16 — generator term output.
- `term` out 16 — captured term, held stable while `term_valid` is high.
- `term_valid` out 1 — a term is offered to the consumer.
- `term_ready` in 1 — the consumer accepts the offered term.
- `term_idx` out CNT_W — 0-based index of the offered term within the job.

## Operation
- The generator produces the sequence 0, 1, 2, 3, 5, 8, 13, … on successive `gen_en` steps after a clear. Each new term appears on `gen_out`, with `gen_valid`=1, in the cycle after `gen_en`.
- States and transitions:
  - IDLE: `start`=1 and `count`≠0 → CLEAR. `start`=1 and `count`=0 → DONE.
  - CLEAR: `gen_rst`=1 → ISSUE.
  - ISSUE: `gen_en`=1 → CAPTURE.
  - CAPTURE: register `gen_out` into `term` → PUSH. If `gen_valid`=0, set `err` and go to DONE instead.
  - PUSH: `term_valid`=1. On `term_ready`=1: increment the index. Index = count → DONE. Otherwise → GAP when `GAP`>0, or → ISSUE when `GAP`=0.
  - GAP: count down `GAP` cycles → ISSUE.
  - DONE: `done`=1 → IDLE.
- `start` is ignored while `busy`=1. A new `count` value has no effect on the job in progress.
- The term index is CNT_W bits wide and never wraps within a job, because it stops at `count`.
- `term` and `term_idx` hold their last values in IDLE.
- Reset values: `busy`, `done`, `err`, `ovf`, `gen_rst`, `gen_en` and `term_valid` are 0; `term` and `term_idx` are 0. The state is IDLE.
- `rst` asserted mid-job aborts the job immediately: no `done` pulse, and the offered term is dropped.

## Timing
- `start` accepted at cycle t:
  - `gen_rst`=1 at t+1.
  - `gen_en`=1 at t+2.
  - Capture at t+3.
  - `term_valid`=1 at t+4.
- Per-term cost is 3 + `GAP` cycles plus any cycles in which `term_ready` is held low.
- `term_valid`, once raised, stays high with `term` and `term_idx` stable until the cycle in which `term_ready`=1. Asserting `term_ready` without `term_valid` has no effect.
- After the final term is accepted in cycle u, `done`=1 at u+1 and `busy`=0 at u+2.
- A job with `count`=0: `done`=1 at t+1; `gen_rst` and `gen_en` are never asserted.
- `gen_en` is never asserted in two consecutive cycles.

## Configuration
- `FIB_OVERFLOW_STOP_EN` defined: in CAPTURE, if the term index is greater than 0 and the captured term is less than the previously captured term (a 16-bit wrap), the controller:
  - discards that term;
  - sets `ovf`;
  - goes to DONE without presenting the term.
- `FIB_OVERFLOW_STOP_EN` undefined: no comparison is made; wrapped terms are delivered as-is and `ovf` is tied to 0.

## Test plan
- `count`=6, `term_ready`=1 constantly, `GAP`=0 → terms 0, 1, 2, 3, 5, 8 at indices 0–5; `term_valid` every 3rd cycle starting at t+4; one `done` pulse.
- `count`=3, `GAP`=2, `term_ready` held low for 4 cycles on index 1 → `term`=1 is held stable for 5 cycles; `gen_en` pulses are spaced at least 5 cycles apart; output sequence 0, 1, 2.
- `count`=0 → `done`=1 at t+1; no `gen_rst`, `gen_en` or `term_valid`.
- `gen_valid` forced to 0 at the second capture → `err`=1 after term 0 only; `done` pulse; `err` clears on the next `start`.
- `count`=30 with `FIB_OVERFLOW_STOP_EN` → 24 terms delivered, ending with 46368 at index 23, then `ovf`=1 and `done`. Without the macro → 30 terms delivered, index 24 = 9489, `ovf`=0.
- `rst` raised during PUSH of index 2, then a new `start` → all outputs are at reset values, and the new job begins again from term 0.

Source files
------------

// File: rtl/fib_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// fib_seq_ctrl_if
//
// Term stream from the Fibonacci sequencing controller to its downstream
// consumer. It uses a valid/ready handshake: a term moves across in any
// cycle where term_valid and term_ready are both high.
//
// Signals:
//   term        captured 16-bit term
//   term_valid  a term is on offer
//   term_ready  the consumer takes the offered term
//   term_idx    0-based index of the offered term within the job
//
// Modports:
//   master  the controller side (drives term, term_valid, term_idx)
//   slave   the consumer side (drives term_ready)
// ----------------------------------------------------------------------------
interface fib_seq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [15:0]      term;
    logic             term_valid;
    logic             term_ready;
    logic [CNT_W-1:0] term_idx;

    modport master (
        output term,
        output term_valid,
        output term_idx,
        input  term_ready
    );

    modport slave (
        input  term,
        input  term_valid,
        input  term_idx,
        output term_ready
    );
endinterface

// File: rtl/fib_seq_ctrl.sv
// ----------------------------------------------------------------------------
// fib_seq_ctrl
//
// Sequencing controller for one 16-bit Fibonacci term generator. A start
// request clears the generator and then steps it exactly `count` times. Each
// step's term is captured and offered to a downstream consumer over a
// valid/ready handshake. After each accepted term the controller waits GAP
// idle cycles before the next step. This block is the only driver of the
// generator's enable and clear.
//
// Parameters:
//   CNT_W  width of the job term count and of the term index
//   GAP    idle cycles between a term's acceptance and the next step (0..255)
//
// Ports:
//   clk, rst     clock (rising edge); synchronous active-high reset
//   start,count  job request and term count, sampled only while idle
//   busy         high in every state except IDLE
//   done         one-cycle pulse at the end of every job
//   err          sticky: the generator failed to raise gen_valid on a step
//   ovf          sticky: the job stopped on a 16-bit wrap (optional feature)
//   gen_rst      one-cycle generator clear
//   gen_en       one-cycle generator step
//   gen_valid    generator term valid, one cycle after gen_en
//   gen_out      generator term
//   term_if      term stream to the consumer (master side)
//
// Build option:
//   FIB_OVERFLOW_STOP_EN  when defined, a captured term that is smaller than
//                         the previous term in the job (a 16-bit wrap) is
//                         discarded. The job then ends with ovf set. When
//                         undefined, wrapped terms are delivered unchanged
//                         and ovf is tied low.
// ----------------------------------------------------------------------------
module fib_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int GAP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic              gen_rst,
    output logic              gen_en,
    input  logic              gen_valid,
    input  logic [15:0]       gen_out,
    fib_seq_ctrl_if.master    term_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_CAPTURE,
        S_PUSH,
        S_GAP,
        S_DONE
    } state_t;

    // The gap counter is loaded with GAP-1 and the state exits when the
    // counter reaches zero, so the GAP state lasts exactly GAP cycles.
    localparam logic [7:0] GAP_INIT = 8'((GAP > 0) ? (GAP - 1) : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_inc;
    logic [CNT_W-1:0] term_idx_q;
    logic [15:0]      term_q;
    logic [7:0]       gap_q;
    logic             err_q;
    logic             accept;
    logic             wrap_hit;

    logic             load_job;
    logic             capture;
    logic             set_err;
    logic             set_ovf;
    logic             gap_load;

    assign accept  = (state_q == S_PUSH) && term_if.term_ready;
    assign idx_inc = idx_q + 1'b1;

`ifdef FIB_OVERFLOW_STOP_EN
    logic ovf_q;

    // term_q still holds the previous term of this job, so it is the
    // reference for detecting a wrap. The first term has no predecessor.
    assign wrap_hit = (idx_q != '0) && (gen_out < term_q);
    assign ovf      = ovf_q;
`else
    assign wrap_hit = 1'b0;
    assign ovf      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        load_job = 1'b0;
        capture  = 1'b0;
        set_err  = 1'b0;
        set_ovf  = 1'b0;
        gap_load = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_job = 1'b1;
                    state_d  = (count == '0) ? S_DONE : S_CLEAR;
                end
            end

            S_CLEAR: state_d = S_ISSUE;

            S_ISSUE: state_d = S_CAPTURE;

            S_CAPTURE: begin
                if (!gen_valid) begin
                    set_err = 1'b1;
                    state_d = S_DONE;
                end else if (wrap_hit) begin
                    set_ovf = 1'b1;
                    state_d = S_DONE;
                end else begin
                    capture = 1'b1;
                    state_d = S_PUSH;
                end
            end

            S_PUSH: begin
                if (term_if.term_ready) begin
                    if (idx_inc == cnt_q) begin
                        state_d = S_DONE;
                    end else if (GAP > 0) begin
                        gap_load = 1'b1;
                        state_d  = S_GAP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = S_ISSUE;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            term_idx_q <= '0;
            term_q     <= '0;
            gap_q      <= '0;
            err_q      <= 1'b0;
`ifdef FIB_OVERFLOW_STOP_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;

            // The job count is latched here. Later changes on `count`
            // do not affect the running job.
            if (load_job) begin
                cnt_q <= count;
                idx_q <= '0;
                err_q <= 1'b0;
`ifdef FIB_OVERFLOW_STOP_EN
                ovf_q <= 1'b0;
`endif
            end

            if (set_err) begin
                err_q <= 1'b1;
            end

`ifdef FIB_OVERFLOW_STOP_EN
            if (set_ovf) begin
                ovf_q <= 1'b1;
            end
`endif

            // term_idx follows the captured term rather than the running
            // counter. That way it keeps the last offered index after the job.
            if (capture) begin
                term_q     <= gen_out;
                term_idx_q <= idx_q;
            end

            if (accept) begin
                idx_q <= idx_inc;
            end

            if (gap_load) begin
                gap_q <= GAP_INIT;
            end else if ((state_q == S_GAP) && (gap_q != 8'd0)) begin
                gap_q <= gap_q - 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign gen_rst = (state_q == S_CLEAR);
    assign gen_en  = (state_q == S_ISSUE);
    assign err     = err_q;

    assign term_if.term       = term_q;
    assign term_if.term_idx   = term_idx_q;
    assign term_if.term_valid = (state_q == S_PUSH);

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fib_seq_ctrl
//
// Two controllers run from one bench: dut0 with GAP=0 and dut2 with GAP=2.
// `sel` chooses which one receives start and is observed. Each controller
// has a behavioural Fibonacci generator (0,1,2,3,5,...) that can suppress
// gen_valid on a chosen step. Expected terms are queued when a job is
// launched. A monitor takes them off the queue as terms are accepted.
// ----------------------------------------------------------------------------
module tb_fib_seq_ctrl;

    localparam int CNT_W = 8;

    typedef struct {
        logic [15:0]      t;
        logic [CNT_W-1:0] i;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       start_v;
    logic [CNT_W-1:0] count;
    logic             term_ready;

    logic [1:0]       busy_v, done_v, err_v, ovf_v, gen_rst_v, gen_en_v, gen_valid_v;
    logic [15:0]      gen_out_v [2];

    fib_seq_ctrl_if #(.CNT_W(CNT_W)) tif0 ();
    fib_seq_ctrl_if #(.CNT_W(CNT_W)) tif2 ();

    assign tif0.term_ready = term_ready;
    assign tif2.term_ready = term_ready;

    fib_seq_ctrl #(.CNT_W(CNT_W), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .count(count),
        .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .ovf(ovf_v[0]),
        .gen_rst(gen_rst_v[0]), .gen_en(gen_en_v[0]),
        .gen_valid(gen_valid_v[0]), .gen_out(gen_out_v[0]),
        .term_if(tif0)
    );

    fib_seq_ctrl #(.CNT_W(CNT_W), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .count(count),
        .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .ovf(ovf_v[1]),
        .gen_rst(gen_rst_v[1]), .gen_en(gen_en_v[1]),
        .gen_valid(gen_valid_v[1]), .gen_out(gen_out_v[1]),
        .term_if(tif2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- observed controller ----------------
    int               sel = 0;
    logic             m_busy, m_done, m_err, m_ovf, m_gen_rst, m_gen_en, m_valid;
    logic [15:0]      m_term;
    logic [CNT_W-1:0] m_idx;

    assign m_busy    = (sel == 1) ? busy_v[1]       : busy_v[0];
    assign m_done    = (sel == 1) ? done_v[1]       : done_v[0];
    assign m_err     = (sel == 1) ? err_v[1]        : err_v[0];
    assign m_ovf     = (sel == 1) ? ovf_v[1]        : ovf_v[0];
    assign m_gen_rst = (sel == 1) ? gen_rst_v[1]    : gen_rst_v[0];
    assign m_gen_en  = (sel == 1) ? gen_en_v[1]     : gen_en_v[0];
    assign m_valid   = (sel == 1) ? tif2.term_valid : tif0.term_valid;
    assign m_term    = (sel == 1) ? tif2.term       : tif0.term;
    assign m_idx     = (sel == 1) ? tif2.term_idx   : tif0.term_idx;

    // ---------------- generator models ----------------
    int          kill_step = -1;
    int          g_step [2];
    logic [15:0] g_last [2];
    logic [15:0] g_prev [2];

    function automatic logic [15:0] gen_term(input int step, input logic [15:0] last,
                                             input logic [15:0] prev);
        if (step < 3) return 16'(step);
        return last + prev;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            gen_valid_v[g] <= 1'b0;
            if (rst || gen_rst_v[g]) begin
                g_step[g]    <= 0;
                g_last[g]    <= 16'd0;
                g_prev[g]    <= 16'd0;
                gen_out_v[g] <= 16'd0;
            end else if (gen_en_v[g]) begin
                gen_out_v[g]   <= gen_term(g_step[g], g_last[g], g_prev[g]);
                g_last[g]      <= gen_term(g_step[g], g_last[g], g_prev[g]);
                g_prev[g]      <= g_last[g];
                gen_valid_v[g] <= !((g == sel) && (g_step[g] == kill_step));
                g_step[g]      <= g_step[g] + 1;
            end
        end
    end

    // Expected term i of a job, with 16-bit wrap.
    function automatic logic [15:0] exp_term(input int i);
        logic [15:0] a, b, c;
        a = 16'd1;
        b = 16'd2;
        if (i < 3) return 16'(i);
        for (int k = 3; k <= i; k++) begin
            c = a + b;
            a = b;
            b = c;
        end
        return b;
    endfunction

    // ---------------- scoreboard and bookkeeping ----------------
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int i, input logic [15:0] t);
        exp_t e;
        e.t = t;
        e.i = CNT_W'(i);
        sb_q.push_back(e);
    endtask

    int          first_valid_cyc = -1;
    int          last_en_cyc     = -1;
    int          min_en_gap      = 1000000;
    int          gen_en_cnt      = 0;
    int          gen_rst_cnt     = 0;
    int          done_cnt        = 0;
    int          valid_cnt       = 0;
    int          hold_len        = 0;
    int          acc_cyc  [256];
    int          acc_hold [256];
    logic [15:0] acc_term [256];

    int   stall_idx  = 0;
    int   stall_left = 0;

    // Consumer: ready is high unless a stall is armed for the offered index.
    initial begin
        term_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (m_valid && (stall_left > 0) && (int'(m_idx) == stall_idx)) begin
                term_ready = 1'b0;
                stall_left--;
            end else begin
                term_ready = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        logic             prev_valid, prev_acc, prev_gen_en;
        logic [15:0]      hold_term;
        logic [CNT_W-1:0] hold_idx;
        exp_t             e;
        prev_valid  = 1'b0;
        prev_acc    = 1'b0;
        prev_gen_en = 1'b0;
        hold_term   = '0;
        hold_idx    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_valid  = 1'b0;
                prev_acc    = 1'b0;
                prev_gen_en = 1'b0;
                hold_len    = 0;
            end else begin
                if (m_gen_en) begin
                    check("gen_en_not_back_to_back", 32'(prev_gen_en), 32'd0);
                    if ((last_en_cyc >= 0) && (cyc - last_en_cyc < min_en_gap))
                        min_en_gap = cyc - last_en_cyc;
                    last_en_cyc = cyc;
                    gen_en_cnt++;
                end
                prev_gen_en = m_gen_en;
                if (m_gen_rst) gen_rst_cnt++;
                if (m_done) done_cnt++;
                if (m_valid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    valid_cnt++;
                    if (prev_valid && !prev_acc) begin
                        check("term_stable", 32'(m_term), 32'(hold_term));
                        check("term_idx_stable", 32'(m_idx), 32'(hold_idx));
                    end else begin
                        hold_len = 0;
                    end
                    hold_len++;
                    hold_term = m_term;
                    hold_idx  = m_idx;
                    if (term_ready) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_term: got term=%0d idx=%0d, expected none",
                                     m_term, m_idx);
                        end else begin
                            e = sb_q.pop_front();
                            check("term_value", 32'(m_term), 32'(e.t));
                            check("term_index", 32'(m_idx), 32'(e.i));
                        end
                        acc_cyc[m_idx]  = cyc;
                        acc_term[m_idx] = m_term;
                        acc_hold[m_idx] = hold_len;
                    end
                end
                prev_valid = m_valid;
                prev_acc   = m_valid && term_ready;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int t_start;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_stats();
        first_valid_cyc = -1;
        last_en_cyc     = -1;
        min_en_gap      = 1000000;
    endtask

    // Called at posedge+1; returns at posedge+1 of cycle t+1.
    task automatic launch(input int g, input int n);
        sel = g;
        reset_stats();
        start_v[g] = 1'b1;
        count      = CNT_W'(n);
        t_start    = cyc;
        tick();
        start_v = '0;
        count   = 8'hAA;
    endtask

    task automatic wait_done(input string name, input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (m_done) begin
                at = cyc;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(at >= 0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int at, d0, r0, e0, v0;
        int n_terms;
        logic [15:0] hand6 [6];
        hand6 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};

        rst     = 1'b1;
        start_v = '0;
        count   = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ctrl_dut0", 32'({busy_v[0], done_v[0], err_v[0], ovf_v[0], gen_rst_v[0],
                                    gen_en_v[0], tif0.term_valid}), 32'd0);
        check("rst_ctrl_dut2", 32'({busy_v[1], done_v[1], err_v[1], ovf_v[1], gen_rst_v[1],
                                    gen_en_v[1], tif2.term_valid}), 32'd0);
        check("rst_term_dut0", 32'({tif0.term, tif0.term_idx}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // count=6, GAP=0, always ready
        for (int i = 0; i < 6; i++) push_exp(i, hand6[i]);
        d0 = done_cnt;
        launch(0, 6);
        @(negedge clk);
        check("t1_gen_rst_t1", 32'(m_gen_rst), 32'd1);
        check("t1_busy_t1", 32'(m_busy), 32'd1);
        @(negedge clk);
        check("t1_gen_en_t2", 32'(m_gen_en), 32'd1);
        check("t1_gen_rst_off_t2", 32'(m_gen_rst), 32'd0);
        wait_done("t1", 100, at);
        check("t1_done_after_last", 32'(at), 32'(acc_cyc[5] + 1));
        @(negedge clk);
        check("t1_idle_busy", 32'(m_busy), 32'd0);
        check("t1_first_valid", 32'(first_valid_cyc), 32'(t_start + 4));
        for (int i = 1; i < 6; i++)
            check("t1_term_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t1_term_hold_idle", 32'(m_term), 32'd8);
        tick();

        // count=3, GAP=2, index 1 stalled for 4 cycles
        for (int i = 0; i < 3; i++) push_exp(i, hand6[i]);
        stall_idx  = 1;
        stall_left = 4;
        launch(1, 3);
        wait_done("t2", 200, at);
        check("t2_hold_len_idx1", 32'(acc_hold[1]), 32'd5);
        check("t2_min_gen_en_gap", 32'(min_en_gap), 32'd5);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // count=0
        r0 = gen_rst_cnt;
        e0 = gen_en_cnt;
        v0 = valid_cnt;
        d0 = done_cnt;
        launch(0, 0);
        @(negedge clk);
        check("t3_done_t1", 32'(m_done), 32'd1);
        @(negedge clk);
        check("t3_idle_t2", 32'(m_busy), 32'd0);
        repeat (4) @(negedge clk);
        check("t3_no_gen_rst", 32'(gen_rst_cnt - r0), 32'd0);
        check("t3_no_gen_en", 32'(gen_en_cnt - e0), 32'd0);
        check("t3_no_term_valid", 32'(valid_cnt - v0), 32'd0);
        check("t3_one_done", 32'(done_cnt - d0), 32'd1);
        tick();

        // gen_valid missing at the second capture
        kill_step = 1;
        push_exp(0, 16'd0);
        v0 = valid_cnt;
        launch(0, 4);
        wait_done("t4", 100, at);
        check("t4_err_set", 32'(m_err), 32'd1);
        check("t4_one_term", 32'(valid_cnt - v0), 32'd1);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check("t4_err_sticky", 32'(m_err), 32'd1);
        tick();
        kill_step = -1;
        push_exp(0, 16'd0);
        launch(0, 1);
        @(negedge clk);
        check("t4_err_cleared", 32'(m_err), 32'd0);
        wait_done("t4b", 100, at);
        check("t4b_sb_empty", 32'(sb_q.size()), 32'd0);
        tick();

        // count=30: wrap at index 24
`ifdef FIB_OVERFLOW_STOP_EN
        n_terms = 24;
`else
        n_terms = 30;
`endif
        for (int i = 0; i < n_terms; i++) push_exp(i, exp_term(i));
        v0 = valid_cnt;
        launch(0, 30);
        wait_done("t5", 400, at);
        check("t5_terms_delivered", 32'(valid_cnt - v0), 32'(n_terms));
        check("t5_idx23", 32'(acc_term[23]), 32'd46368);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t5_no_err", 32'(m_err), 32'd0);
`ifdef FIB_OVERFLOW_STOP_EN
        check("t5_ovf_set", 32'(m_ovf), 32'd1);
        check("t5_last_idx", 32'(m_idx), 32'd23);
`else
        check("t5_idx24", 32'(acc_term[24]), 32'd9489);
        check("t5_ovf_clear", 32'(m_ovf), 32'd0);
`endif
        tick();

        // rst while index 2 is offered and stalled
        for (int i = 0; i < 3; i++) push_exp(i, hand6[i]);
        stall_idx  = 2;
        stall_left = 1000;
        d0 = done_cnt;
        launch(0, 5);
        at = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (m_valid && (m_idx == 8'd2)) begin
                at = cyc;
                break;
            end
        end
        check("t6_idx2_offered", 32'(at >= 0), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        stall_left = 0;
        sb_q.delete();
        @(negedge clk);
        check("t6_rst_ctrl", 32'({m_busy, m_done, m_err, m_ovf, m_gen_rst, m_gen_en, m_valid}),
              32'd0);
        check("t6_rst_term", 32'(m_term), 32'd0);
        check("t6_rst_idx", 32'(m_idx), 32'd0);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) push_exp(i, hand6[i]);
        launch(0, 3);
        wait_done("t6b", 100, at);
        check("t6b_first_valid", 32'(first_valid_cyc), 32'(t_start + 4));
        check("t6b_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
